// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared decode constants and IF/ID buffer type
package id_stage_pkg;

  localparam int          NUM_REGS = 8;
  localparam int          IDX_W    = $clog2(NUM_REGS);
  localparam logic [15:0] NOP_WORD = 16'd0;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ALU   = 4'd1;
  localparam logic [3:0] OP_ITYPE = 4'd8;
  localparam logic [3:0] OP_LDD   = 4'd9;
  localparam logic [3:0] OP_STD   = 4'd10;

  localparam int OPC_LSB  = 12;
  localparam int RD_LSB   = 9;
  localparam int RS1_LSB  = 6;
  localparam int RS2_LSB  = 3;
  localparam int FUNC_LSB = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        intr;
  } ifid_t;

  function automatic logic uses_rs1(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_ITYPE);
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    return (op == OP_ALU) || (op == OP_STD);
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch-to-decode bus with stall returned to fetch
interface id_stage_if;
  logic [31:0] PC_IF_in;
  logic [15:0] instr_in;
  logic [15:0] Data_in;
  logic        INT_in;
  logic        stall;

  modport master (output PC_IF_in, output instr_in, output Data_in, output INT_in, input stall);
  modport slave  (input PC_IF_in, input instr_in, input Data_in, input INT_in, output stall);
endinterface

// File: rtl/id_stage_reg_file.sv
// rtl/id_stage_reg_file.sv - 2R1W register file with write-through read bypass
module reg_file #(
  parameter int NREGS = 8,
  parameter int W     = 16,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [W-1:0]  wr_data,
  input  logic [IW-1:0] rd_idx_a,
  output logic [W-1:0]  rd_data_a,
  input  logic [IW-1:0] rd_idx_b,
  output logic [W-1:0]  rd_data_b
);

  logic [W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Bypass is suppressed in reset since the write it forwards will not land.
  assign rd_data_a = (reset && wr_en && wr_idx == rd_idx_a) ? wr_data : regs[rd_idx_a];
  assign rd_data_b = (reset && wr_en && wr_idx == rd_idx_b) ? wr_data : regs[rd_idx_b];

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: IF/ID buffer, field decode, regfile read, load-use stall
module id_stage
  import id_stage_pkg::*;
#(
  parameter int          NREGS    = 8,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic             clk,
  input  logic             reset,
  id_stage_if.slave        fetch,
  input  logic             flush,
  input  logic             ex_mem_read,
  input  logic [IDX_W-1:0] ex_rd,
  input  logic             wb_en,
  input  logic [IDX_W-1:0] wb_idx,
  input  logic [15:0]      wb_data,
  output logic [31:0]      PC_ID_out,
  output logic [15:0]      imm_out,
  output logic             INT_out,
  output logic [3:0]       opcode,
  output logic [2:0]       rd_idx,
  output logic [2:0]       rs1_idx,
  output logic [2:0]       rs2_idx,
  output logic [2:0]       func,
  output logic [15:0]      rs1_data,
  output logic [15:0]      rs2_data,
  output logic             valid
);

  localparam ifid_t BUF_RST = '{pc: RESET_PC, instr: NOP_WORD, imm: 16'd0, intr: 1'b0};

  ifid_t buf_q;
  logic  buf_valid;
  logic  hazard;
  logic  stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q <= BUF_RST;
    end else if (flush) begin
      buf_q <= BUF_RST;
    end else if (!stall) begin
      buf_q <= '{pc: fetch.PC_IF_in, instr: fetch.instr_in, imm: fetch.Data_in, intr: fetch.INT_in};
    end
  end

  assign opcode    = buf_q.instr[OPC_LSB +: 4];
  assign rd_idx    = buf_q.instr[RD_LSB +: 3];
  assign rs1_idx   = buf_q.instr[RS1_LSB +: 3];
  assign rs2_idx   = buf_q.instr[RS2_LSB +: 3];
  assign func      = buf_q.instr[FUNC_LSB +: 3];
  assign PC_ID_out = buf_q.pc;
  assign imm_out   = buf_q.imm;
  assign INT_out   = buf_q.intr;

  // An interrupt slot carries opcode 0, so it naturally claims no sources.
  assign buf_valid = (buf_q.instr != NOP_WORD) || buf_q.intr;
  assign hazard    = (uses_rs1(opcode) && ex_rd == rs1_idx) ||
                     (uses_rs2(opcode) && ex_rd == rs2_idx);
  assign stall     = ex_mem_read && buf_valid && hazard && !flush;
  assign valid     = buf_valid && !stall;

  assign fetch.stall = stall;

  reg_file #(.NREGS(NREGS), .W(16)) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wb_en),
    .wr_idx    (wb_idx),
    .wr_data   (wb_data),
    .rd_idx_a  (rs1_idx),
    .rd_data_a (rs1_data),
    .rd_idx_b  (rs2_idx),
    .rd_data_b (rs2_data)
  );

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage
module tb_id_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        intr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [2:0]  ex_rd = 3'd0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_idx = 3'd0;
  logic [15:0] wb_data = 16'd0;
  logic [31:0] PC_ID_out;
  logic [15:0] imm_out;
  logic        INT_out;
  logic [3:0]  opcode;
  logic [2:0]  rd_idx, rs1_idx, rs2_idx, func;
  logic [15:0] rs1_data, rs2_data;
  logic        valid;

  id_stage_if fetch_bus ();

  id_stage #(.NREGS(8), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .fetch(fetch_bus), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .PC_ID_out(PC_ID_out), .imm_out(imm_out), .INT_out(INT_out),
    .opcode(opcode), .rd_idx(rd_idx), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .func(func),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .valid(valid)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        e;
  logic [15:0] mregs [8];

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] fn);
    return {op, rd, s1, s2, fn};
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] idx);
    return (wb_en && wb_idx == idx) ? wb_data : mregs[idx];
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [15:0] instr,
                       input logic [15:0] imm, input logic intr);
    fetch_bus.PC_IF_in = pc;
    fetch_bus.instr_in = instr;
    fetch_bus.Data_in  = imm;
    fetch_bus.INT_in   = intr;
  endtask

  task automatic push_fetch(input logic [31:0] pc, input logic [15:0] instr,
                            input logic [15:0] imm, input logic intr);
    exp_t x;
    drive(pc, instr, imm, intr);
    x.pc = pc; x.instr = instr; x.imm = imm; x.intr = intr;
    sb.push_back(x);
  endtask

  task automatic tick();
    if (reset && wb_en) mregs[wb_idx] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp();
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: scoreboard has 0 entries, required at least 1");
      e.pc = 'x; e.instr = 'x; e.imm = 'x; e.intr = 1'bx;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(32'h0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
    repeat (3) tick();
    n_checks++;
    if (fetch_bus.stall !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: stall=%b valid=%b required 0 0", fetch_bus.stall, valid);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (PC_ID_out !== RESET_PC || imm_out !== 16'd0 || INT_out !== 1'b0 || opcode !== 4'd0 ||
        rd_idx !== 3'd0 || rs1_idx !== 3'd0 || rs2_idx !== 3'd0 || func !== 3'd0 ||
        rs1_data !== 16'd0 || rs2_data !== 16'd0 || valid !== 1'b0 || fetch_bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: pc=%h imm=%h int=%b op=%h rs1d=%h rs2d=%h valid=%b stall=%b required pc=%h rest 0",
               PC_ID_out, imm_out, INT_out, opcode, rs1_data, rs2_data, valid, fetch_bus.stall, RESET_PC);
    end
    for (int i = 0; i < 8; i++) begin
      push_fetch(32'h1000 + 32'(i), enc(4'd1, 3'd0, 3'(i), 3'(7 - i), 3'd0), 16'h0, 1'b0);
      tick();
      pop_exp();
      n_checks++;
      if (rs1_data !== 16'd0 || rs2_data !== 16'd0 || PC_ID_out !== e.pc) begin
        n_fail++;
        $display("FAIL reset_regs[%0d]: rs1d=%h rs2d=%h pc=%h required 0 0 %h", i, rs1_data, rs2_data, PC_ID_out, e.pc);
      end
    end
  endtask

  task automatic test_bypass();
    push_fetch(32'h10, enc(4'd1, 3'd1, 3'd3, 3'd0, 3'd0), 16'h0011, 1'b0);
    tick();
    pop_exp();
    wb_en = 1'b1; wb_idx = 3'd3; wb_data = 16'hBEEF;
    #1;
    n_checks++;
    if (rs1_idx !== 3'd3 || rs1_data !== 16'hBEEF || PC_ID_out !== e.pc) begin
      n_fail++;
      $display("FAIL bypass_same: rs1_idx=%0d rs1d=%h pc=%h required 3 beef %h", rs1_idx, rs1_data, PC_ID_out, e.pc);
    end
    push_fetch(32'h12, enc(4'd1, 3'd1, 3'd3, 3'd0, 3'd0), 16'h0012, 1'b0);
    tick();
    wb_en = 1'b0;
    #1;
    pop_exp();
    n_checks++;
    if (rs1_data !== 16'hBEEF || PC_ID_out !== e.pc) begin
      n_fail++;
      $display("FAIL bypass_next: rs1d=%h pc=%h required beef %h", rs1_data, PC_ID_out, e.pc);
    end
  endtask

  task automatic test_load_use();
    push_fetch(32'h20, enc(4'd1, 3'd0, 3'd2, 3'd1, 3'd0), 16'h2222, 1'b0);
    tick();
    pop_exp();
    ex_mem_read = 1'b1; ex_rd = 3'd2;
    push_fetch(32'h24, enc(4'd9, 3'd4, 3'd5, 3'd6, 3'd1), 16'h2424, 1'b0);
    #1;
    n_checks++;
    if (fetch_bus.stall !== 1'b1 || valid !== 1'b0 || PC_ID_out !== e.pc) begin
      n_fail++;
      $display("FAIL loaduse_stall: stall=%b valid=%b pc=%h required 1 0 %h", fetch_bus.stall, valid, PC_ID_out, e.pc);
    end
    tick();
    ex_mem_read = 1'b0;
    #1;
    n_checks++;
    if (fetch_bus.stall !== 1'b0 || valid !== 1'b1 || PC_ID_out !== e.pc ||
        opcode !== e.instr[15:12] || rs1_idx !== e.instr[8:6] || imm_out !== e.imm) begin
      n_fail++;
      $display("FAIL loaduse_release: stall=%b valid=%b pc=%h op=%h rs1=%0d required 0 1 %h %h %0d",
               fetch_bus.stall, valid, PC_ID_out, opcode, rs1_idx, e.pc, e.instr[15:12], e.instr[8:6]);
    end
    tick();
    pop_exp();
    n_checks++;
    if (PC_ID_out !== e.pc || opcode !== e.instr[15:12] || imm_out !== e.imm || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL loaduse_next: pc=%h op=%h imm=%h valid=%b required %h %h %h 1",
               PC_ID_out, opcode, imm_out, valid, e.pc, e.instr[15:12], e.imm);
    end
  endtask

  task automatic test_no_false_hazard();
    push_fetch(32'h30, enc(4'd8, 3'd1, 3'd5, 3'd5, 3'd2), 16'h3030, 1'b0);
    tick();
    pop_exp();
    ex_mem_read = 1'b1; ex_rd = 3'd5;
    #1;
    n_checks++;
    if (fetch_bus.stall !== 1'b0 || valid !== 1'b1 || PC_ID_out !== e.pc) begin
      n_fail++;
      $display("FAIL itype_nohaz: stall=%b valid=%b pc=%h required 0 1 %h", fetch_bus.stall, valid, PC_ID_out, e.pc);
    end
    ex_mem_read = 1'b0;
  endtask

  task automatic test_flush_vs_stall();
    exp_t x;
    push_fetch(32'h34, enc(4'd1, 3'd0, 3'd4, 3'd4, 3'd0), 16'h3434, 1'b0);
    tick();
    pop_exp();
    ex_mem_read = 1'b1; ex_rd = 3'd4; flush = 1'b1;
    drive(32'h38, enc(4'd1, 3'd2, 3'd2, 3'd2, 3'd2), 16'h3838, 1'b0);
    x.pc = RESET_PC; x.instr = 16'd0; x.imm = 16'd0; x.intr = 1'b0;
    sb.push_back(x);
    #1;
    n_checks++;
    if (fetch_bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall: stall=%b required 0", fetch_bus.stall);
    end
    tick();
    flush = 1'b0; ex_mem_read = 1'b0;
    drive(32'h0, 16'h0, 16'h0, 1'b0);
    #1;
    pop_exp();
    n_checks++;
    if (opcode !== e.instr[15:12] || rs1_idx !== 3'd0 || valid !== 1'b0 || PC_ID_out !== e.pc || imm_out !== e.imm) begin
      n_fail++;
      $display("FAIL flush_bubble: op=%h rs1=%0d valid=%b pc=%h imm=%h required 0 0 0 %h 0",
               opcode, rs1_idx, valid, PC_ID_out, imm_out, e.pc);
    end
  endtask

  task automatic test_interrupt();
    push_fetch(32'h40, 16'h0, 16'hABCD, 1'b1);
    ex_mem_read = 1'b1; ex_rd = 3'd0;
    tick();
    pop_exp();
    n_checks++;
    if (valid !== 1'b1 || INT_out !== 1'b1 || PC_ID_out !== 32'h40 || imm_out !== e.imm || fetch_bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL int_slot: valid=%b int=%b pc=%h imm=%h stall=%b required 1 1 00000040 %h 0",
               valid, INT_out, PC_ID_out, imm_out, fetch_bus.stall, e.imm);
    end
    ex_mem_read = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins;
    logic        it;
    logic [15:0] exp_rs1, exp_rs2;
    for (int k = 0; k < 40; k++) begin
      ins = 16'($urandom_range(0, 16'hFFFF));
      if (k % 7 == 0) ins = 16'h0;
      it = (k % 11 == 3);
      push_fetch(32'h2000 + 32'(k * 2), ins, 16'($urandom_range(0, 16'hFFFF)), it);
      tick();
      wb_en = ($urandom_range(0, 1) == 1);
      wb_idx = 3'($urandom_range(0, 7));
      wb_data = 16'($urandom_range(0, 16'hFFFF));
      #1;
      pop_exp();
      exp_rs1 = model_read(e.instr[8:6]);
      exp_rs2 = model_read(e.instr[5:3]);
      n_checks++;
      if (PC_ID_out !== e.pc || imm_out !== e.imm || INT_out !== e.intr ||
          {opcode, rd_idx, rs1_idx, rs2_idx, func} !== e.instr ||
          rs1_data !== exp_rs1 || rs2_data !== exp_rs2 ||
          valid !== ((e.instr != 16'd0) || e.intr) || fetch_bus.stall !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b[%0d]: pc=%h instr=%h rs1d=%h rs2d=%h valid=%b required pc=%h instr=%h rs1d=%h rs2d=%h",
                 k, PC_ID_out, {opcode, rd_idx, rs1_idx, rs2_idx, func}, rs1_data, rs2_data, valid,
                 e.pc, e.instr, exp_rs1, exp_rs2);
      end
    end
    wb_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    wb_en = 1'b1; wb_idx = 3'd6; wb_data = 16'h5555;
    mregs[3] = 16'hBEEF;
    reset = 1'b0;
    #1;
    n_checks++;
    if (fetch_bus.stall !== 1'b0 || valid !== 1'b0 || PC_ID_out !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_mid: stall=%b valid=%b pc=%h required 0 0 %h", fetch_bus.stall, valid, PC_ID_out, RESET_PC);
    end
    tick();
    reset = 1'b1;
    wb_en = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
    push_fetch(32'h50, enc(4'd1, 3'd0, 3'd6, 3'd3, 3'd0), 16'h0, 1'b0);
    tick();
    pop_exp();
    n_checks++;
    if (rs1_data !== mregs[6] || rs2_data !== mregs[3] || PC_ID_out !== e.pc) begin
      n_fail++;
      $display("FAIL reset_mid_regs: rs1d=%h rs2d=%h pc=%h required 0 0 %h", rs1_data, rs2_data, PC_ID_out, e.pc);
    end
  endtask

  initial begin
    drive(32'h0, 16'h0, 16'h0, 1'b0);
    test_reset();
    test_bypass();
    test_load_use();
    test_no_false_hazard();
    test_flush_vs_stall();
    test_interrupt();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries remain, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
